// File: rtl/leaf_out_packetizer.sv
// Output stage of a leaf interface: merges user output streams into one BFT packet
// stream with round-robin arbitration, per-port credits, address stamping and resend squash.
`timescale 1ns/1ps
module leaf_out_packetizer #(
  parameter int PACKET_BITS           = 49,
  parameter int PAYLOAD_BITS          = 32,
  parameter int NUM_LEAF_BITS         = 5,
  parameter int NUM_PORT_BITS         = 4,
  parameter int NUM_ADDR_BITS         = 7,
  parameter int NUM_OUT_PORTS         = 4,
  parameter int NUM_BRAM_ADDR_BITS    = 7,
  parameter int FREESPACE_UPDATE_SIZE = 64
) (
  input  logic                                                clk,
  input  logic                                                reset,
  input  logic                                                resend,
  input  logic [NUM_OUT_PORTS*PAYLOAD_BITS-1:0]               din_leaf_user2interface,
  input  logic [NUM_OUT_PORTS-1:0]                            vld_user2interface,
  output logic [NUM_OUT_PORTS-1:0]                            ack_interface2user,
  input  logic [NUM_OUT_PORTS*(NUM_LEAF_BITS+NUM_PORT_BITS)-1:0] dest_cfg,
  input  logic [NUM_OUT_PORTS-1:0]                            credit_return,
  input  logic                                                bft_ready,
  output logic [PACKET_BITS-1:0]                              dout_leaf_interface2bft
);

  localparam int DW = NUM_LEAF_BITS + NUM_PORT_BITS;
  localparam int PW = (NUM_OUT_PORTS > 1) ? $clog2(NUM_OUT_PORTS) : 1;
  localparam int CW = NUM_BRAM_ADDR_BITS + 1;
  localparam logic [CW-1:0] CREDIT_MAX = {1'b1, {NUM_BRAM_ADDR_BITS{1'b0}}};
  localparam logic [PW:0]   PORTS_W    = (PW+1)'(NUM_OUT_PORTS);
  localparam logic [PW-1:0] LAST_PORT  = PW'(NUM_OUT_PORTS - 1);

  if (PACKET_BITS != 1 + NUM_LEAF_BITS + NUM_PORT_BITS + NUM_ADDR_BITS + PAYLOAD_BITS) begin : g_bad_packet_bits
    $error("PACKET_BITS must equal 1+NUM_LEAF_BITS+NUM_PORT_BITS+NUM_ADDR_BITS+PAYLOAD_BITS");
  end
  if (NUM_OUT_PORTS < 1 || NUM_OUT_PORTS > 16) begin : g_bad_num_ports
    $error("NUM_OUT_PORTS must be in 1..16");
  end

  logic [NUM_OUT_PORTS-1:0][PAYLOAD_BITS-1:0]  payload_all;
  logic [NUM_OUT_PORTS-1:0][DW-1:0]            dest_all;
  logic [NUM_OUT_PORTS-1:0][NUM_ADDR_BITS-1:0] addr_all;
  logic [NUM_OUT_PORTS-1:0]                    eligible;
  logic [PACKET_BITS-1:0]                      out_reg;
  logic [PW-1:0]                               rr_ptr_reg;
  logic [PW-1:0]                               rr_ptr_next;
  logic [PW-1:0]                               grant_idx;
  logic [PW:0]                                 cand;
  logic                                        grant_found;
  logic                                        load_en;
  logic                                        grant_valid;

  assign payload_all = din_leaf_user2interface;
  assign dest_all    = dest_cfg;

  // The output register may only be refilled when empty or being drained.
  assign load_en     = !resend && (!out_reg[PACKET_BITS-1] || bft_ready);
  assign grant_valid = load_en && !reset && grant_found;

  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int k = 0; k < NUM_OUT_PORTS; k++) begin
      cand = {1'b0, rr_ptr_reg} + (PW+1)'(k);
      if (cand >= PORTS_W) cand = cand - PORTS_W;
      if (!grant_found && eligible[cand[PW-1:0]]) begin
        grant_found = 1'b1;
        grant_idx   = cand[PW-1:0];
      end
    end
  end

  always_comb begin
    ack_interface2user = '0;
    if (grant_valid) ack_interface2user[grant_idx] = 1'b1;
  end

  assign rr_ptr_next = (grant_idx == LAST_PORT) ? '0 : grant_idx + 1'b1;

  always_ff @(posedge clk) begin
    if (reset) begin
      out_reg    <= '0;
      rr_ptr_reg <= '0;
    end else if (load_en) begin
      if (grant_found) begin
        out_reg    <= {1'b1, dest_all[grant_idx], addr_all[grant_idx], payload_all[grant_idx]};
        rr_ptr_reg <= rr_ptr_next;
      end else begin
        out_reg <= '0;
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_OUT_PORTS; gi++) begin : g_port
      logic [CW-1:0]            credit_reg;
      logic [CW-1:0]            credit_next;
      logic [31:0]              credit_sum;
      logic [NUM_ADDR_BITS-1:0] addr_reg;

      assign eligible[gi] = vld_user2interface[gi] && (credit_reg != '0);
      assign addr_all[gi] = addr_reg;

      // Returns are honoured even while stalled or resending; the sum saturates at full depth.
      always_comb begin
        credit_sum = 32'(credit_reg);
        if (credit_return[gi])      credit_sum = credit_sum + 32'(FREESPACE_UPDATE_SIZE);
        if (ack_interface2user[gi]) credit_sum = credit_sum - 32'd1;
        credit_next = (credit_sum > 32'(CREDIT_MAX)) ? CREDIT_MAX : credit_sum[CW-1:0];
      end

      always_ff @(posedge clk) begin
        if (reset) begin
          credit_reg <= CREDIT_MAX;
          addr_reg   <= '0;
        end else begin
          credit_reg <= credit_next;
          if (ack_interface2user[gi]) addr_reg <= addr_reg + 1'b1;
        end
      end
    end
  endgenerate

  assign dout_leaf_interface2bft = resend ? '0 : out_reg;

endmodule
